// File: rtl/bids22_results_pkg.sv
// Shared types and constants for the bids22 round-results logger.
// Stored bid fields are sized to MAX_BID_WIDTH so the top may use any DATAWIDTH up to it.
package bids22defs;

  localparam int MAX_BID_WIDTH = 64;
  localparam logic [1:0] NOWINNER = 2'b11;

  typedef enum logic {
    WAIT_RO = 1'b0,
    HOLD    = 1'b1
  } cap_state_t;

  typedef struct packed {
    logic [7:0]               round;
    logic [MAX_BID_WIDTH-1:0] max_bid;
    logic [1:0]               winner;
  } result_t;

endpackage

// File: rtl/bids22_results_fifo.sv
// First-word-fall-through result FIFO: the head entry is visible on rd_data with no read latency.
// Storage is not reset; only pointers and occupancy are.
module bids22_results_fifo
  import bids22defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  result_t                    wr_data,
  output result_t                    rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  result_t         mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bids22_results.sv
// Captures one auction result per round_over pulse, tags it with a round number and
// queues it for a consumer; tracks dropped results and multi-winner rounds.
module bids22_results
  import bids22defs::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       round_over,
  input  logic [DATAWIDTH-1:0]       max_bid,
  input  logic [NUMBIDDERS-1:0]      win,
  input  logic                       clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [7:0]                 rd_round,
  output logic [DATAWIDTH-1:0]       rd_max_bid,
  output logic [1:0]                 rd_winner,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       multi_win
);

  cap_state_t state;
  cap_state_t next_state;
  logic       capture;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       several_wins;
  logic [1:0] winner_idx;
  logic [7:0] round_cnt;
  result_t    cap_entry;
  result_t    head;

  // A clear during a high round_over parks in HOLD so the rest of that period is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= WAIT_RO;
    else if (clr)  state <= round_over ? HOLD : WAIT_RO;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_RO: if (round_over)  next_state = HOLD;
      HOLD:    if (!round_over) next_state = WAIT_RO;
      default: next_state = WAIT_RO;
    endcase
  end

  always_comb begin
    capture = (state == WAIT_RO) && round_over && !clr;
  end

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    winner_idx = NOWINNER;
    for (int i = NUMBIDDERS - 1; i >= 0; i--) begin
      if (win[i]) winner_idx = 2'(i);
    end
  end

  assign several_wins = ($countones(win) > 1);
  assign pop          = rd_valid && rd_ready;
  assign cap_entry    = '{round: round_cnt, max_bid: MAX_BID_WIDTH'(max_bid), winner: winner_idx};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_cnt <= '0;
      overflow  <= 1'b0;
      multi_win <= 1'b0;
    end else if (clr) begin
      round_cnt <= '0;
      overflow  <= 1'b0;
      multi_win <= 1'b0;
    end else if (capture) begin
      round_cnt <= round_cnt + 1'b1;
      if (fifo_full && !pop) overflow  <= 1'b1;
      if (several_wins)      multi_win <= 1'b1;
    end
  end

  bids22_results_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (capture),
    .pop     (pop),
    .wr_data (cap_entry),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign rd_valid   = !fifo_empty;
  assign rd_round   = head.round;
  assign rd_max_bid = DATAWIDTH'(head.max_bid);
  assign rd_winner  = head.winner;

endmodule
